// File: rtl/issue_queue_pkg.sv
// Shared widths and the renamed-instruction record exchanged between rename and issue.
package issue_queue_pkg;

  localparam int unsigned NUM_PHYS_REG = 64;
  localparam int unsigned NUM_ARCH_REG = 32;
  localparam int unsigned WORD_SIZE_P = 32;
  localparam int unsigned PHYS_REG_ID_W = $clog2(NUM_PHYS_REG);

  typedef struct packed {
    logic [WORD_SIZE_P-1:0]   pc;
    logic [PHYS_REG_ID_W-1:0] source_1;
    logic [WORD_SIZE_P-1:0]   source2_imm;
    logic                     imm;
    logic                     w_v;
    logic [PHYS_REG_ID_W-1:0] dest_id;
    logic [5:0]               op;
  } renamed_instruction_t;

  localparam int unsigned RENAMED_INSTRUCTION_WIDTH = $bits(renamed_instruction_t);

endpackage

// File: rtl/issue_queue_if.sv
// Rename-side, FU-side, writeback and flush signals of the issue queue.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
    parameter int unsigned Depth = 8
) ();

    renamed_instruction_t         renamed_i;
    logic                         renamed_v_i;
    logic                         issue_rename_ready_o;
    renamed_instruction_t         issued_o;
    logic                         issued_v_o;
    logic                         fu_issue_ready_i;
    logic                         wb_v_i;
    logic [PHYS_REG_ID_W-1:0]     wb_preg_i;
    logic                         flush_i;
    logic [$clog2(Depth):0]       count_o;

    modport slave (
        input  renamed_i, renamed_v_i, fu_issue_ready_i, wb_v_i, wb_preg_i, flush_i,
        output issue_rename_ready_o, issued_o, issued_v_o, count_o
    );

    modport master (
        output renamed_i, renamed_v_i, fu_issue_ready_i, wb_v_i, wb_preg_i, flush_i,
        input  issue_rename_ready_o, issued_o, issued_v_o, count_o
    );

endinterface

// File: rtl/issue_queue.sv
// In-order issue FIFO with a physical-register ready scoreboard; the head issues once
// its sources are written (same-cycle writeback bypass), and a flush empties everything.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input logic          clk_i,
    input logic          reset_i,
    issue_queue_if.slave bus
);

    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned PregW = PHYS_REG_ID_W;
    localparam logic [NUM_PHYS_REG-1:0] SbReset =
        {{(NUM_PHYS_REG - NUM_ARCH_REG){1'b0}}, {NUM_ARCH_REG{1'b1}}};

    renamed_instruction_t    mem_q [Depth];
    logic [PtrW-1:0]         head_q, tail_q;
    logic [CntW-1:0]         count_q, count_d;
    logic [NUM_PHYS_REG-1:0] sb_q, sb_d;

    logic [PregW-1:0] src1, src2;
    logic             head_imm, src1_rdy, src2_rdy;
    logic             ready, issue_v, enq, deq;

    always_comb begin
        src1     = mem_q[head_q].source_1;
        src2     = mem_q[head_q].source2_imm[PregW-1:0];
        head_imm = mem_q[head_q].imm;
        src1_rdy = sb_q[src1] | (bus.wb_v_i && (bus.wb_preg_i == src1));
        src2_rdy = sb_q[src2] | (bus.wb_v_i && (bus.wb_preg_i == src2));
        // Ready looks only at occupancy and flush, never at renamed_v_i.
        ready    = (count_q < CntW'(Depth)) && !bus.flush_i;
        issue_v  = (count_q != '0) && !bus.flush_i && src1_rdy && (head_imm || src2_rdy);
        enq      = bus.renamed_v_i && ready;
        deq      = issue_v && bus.fu_issue_ready_i;
    end

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Writeback sets, a destination claim clears (wins on a tie), flush sets all.
    always_comb begin
        sb_d = sb_q;
        if (bus.wb_v_i) sb_d[bus.wb_preg_i] = 1'b1;
        if (enq && bus.renamed_i.w_v) sb_d[bus.renamed_i.dest_id] = 1'b0;
        if (bus.flush_i) sb_d = '1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            sb_q    <= SbReset;
        end else begin
            sb_q <= sb_d;
            if (bus.flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) tail_q <= tail_q + 1'b1;
                if (deq) head_q <= head_q + 1'b1;
                count_q <= count_d;
            end
        end
    end

    // Entry storage needs no reset; it is only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[tail_q] <= bus.renamed_i;
    end

    assign bus.issue_rename_ready_o = ready;
    assign bus.issued_v_o           = issue_v;
    assign bus.issued_o             = mem_q[head_q];
    assign bus.count_o              = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed bench for issue_queue against a queue-based reference model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int unsigned Depth = 8;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    issue_queue_if #(.Depth(Depth)) bus ();

    issue_queue #(.Depth(Depth)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    renamed_instruction_t mq[$];
    bit msb[NUM_PHYS_REG];
    int pc_seq = 0;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < NUM_PHYS_REG; i++) msb[i] = (i < NUM_ARCH_REG);
    endfunction

    function automatic bit mrdy(input int p, input logic wv, input logic [5:0] wp);
        return msb[p] || (wv && (int'(wp) == p));
    endfunction

    function automatic renamed_instruction_t mk(input int s1, input int s2, input bit im,
                                                input bit wv, input int dst);
        renamed_instruction_t r;
        r.pc          = 32'h1000 + 32'(pc_seq * 4);
        r.source_1    = 6'(s1);
        r.source2_imm = {26'(pc_seq), 6'(s2)};
        r.imm         = im;
        r.w_v         = wv;
        r.dest_id     = 6'(dst);
        r.op          = 6'(pc_seq);
        pc_seq++;
        return r;
    endfunction

    // Entered and left at a falling edge: drive, check at +1, then advance the model.
    task automatic cycle(input logic v, input renamed_instruction_t ins, input logic fr,
                         input logic wv, input logic [5:0] wp, input logic fl,
                         output logic got_v, output logic got_ready);
        bit exp_ready, exp_v, enq, deq;
        bus.renamed_v_i      = v;
        bus.renamed_i        = ins;
        bus.fu_issue_ready_i = fr;
        bus.wb_v_i           = wv;
        bus.wb_preg_i        = wp;
        bus.flush_i          = fl;
        #1;
        exp_ready = (mq.size() < Depth) && !fl;
        exp_v = 1'b0;
        if (mq.size() != 0 && !fl)
            exp_v = mrdy(int'(mq[0].source_1), wv, wp) &&
                    (mq[0].imm || mrdy(int'(mq[0].source2_imm[5:0]), wv, wp));
        chk("ready", bus.issue_rename_ready_o, exp_ready);
        chk("issued_v", bus.issued_v_o, exp_v);
        chk("count", bus.count_o, mq.size());
        if (mq.size() != 0) chk("issued_entry", bus.issued_o, mq[0]);
        got_v     = bus.issued_v_o;
        got_ready = bus.issue_rename_ready_o;
        enq = v && exp_ready;
        deq = exp_v && fr;
        @(posedge clk_i);
        if (fl) begin
            mq.delete();
            for (int i = 0; i < NUM_PHYS_REG; i++) msb[i] = 1'b1;
        end else begin
            if (wv) msb[wp] = 1'b1;
            if (enq && ins.w_v) msb[ins.dest_id] = 1'b0;
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back(ins);
        end
        @(negedge clk_i);
    endtask

    renamed_instruction_t idle, ins;
    logic gv, gr;

    initial begin
        idle = '0;
        reset_i = 1'b1;
        bus.renamed_v_i = 1'b0;
        bus.renamed_i = '0;
        bus.fu_issue_ready_i = 1'b0;
        bus.wb_v_i = 1'b0;
        bus.wb_preg_i = '0;
        bus.flush_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_count", bus.count_o, 0);
        chk("rst_issued_v", bus.issued_v_o, 0);
        reset_i = 1'b0;
        #1;
        chk("rst_ready", bus.issue_rename_ready_o, 1);
        @(negedge clk_i);

        // Asynchronous reset with three entries queued.
        repeat (3) cycle(1, mk(3, 4, 0, 0, 0), 0, 0, 0, 0, gv, gr);
        chk("pre_rst_count", bus.count_o, 3);
        bus.renamed_v_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("async_rst_count", bus.count_o, 0);
        chk("async_rst_issued_v", bus.issued_v_o, 0);
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        cycle(1, mk(3, 0, 1, 0, 0), 0, 0, 0, 0, gv, gr);
        cycle(0, idle, 1, 0, 0, 0, gv, gr);
        chk("p3_issue_after_1", gv, 1);

        // Dependency stall with writeback bypass.
        cycle(1, mk(1, 0, 1, 1, 9), 0, 0, 0, 0, gv, gr);
        cycle(1, mk(9, 0, 1, 0, 0), 0, 0, 0, 0, gv, gr);
        cycle(0, idle, 1, 0, 0, 0, gv, gr);
        chk("dep_a_issues", gv, 1);
        cycle(0, idle, 1, 0, 0, 0, gv, gr);
        chk("dep_b_held", gv, 0);
        cycle(0, idle, 1, 1, 6'd9, 0, gv, gr);
        chk("dep_b_bypass", gv, 1);

        // Fill to capacity with the FUs stalled.
        repeat (8) cycle(1, mk(0, 0, 1, 0, 0), 0, 0, 0, 0, gv, gr);
        chk("full_count", bus.count_o, 8);
        cycle(1, mk(0, 0, 1, 0, 0), 0, 0, 0, 0, gv, gr);
        chk("full_ready", gr, 0);
        chk("full_no_enq", bus.count_o, 8);
        cycle(0, idle, 1, 0, 0, 0, gv, gr);
        chk("full_one_deq", bus.count_o, 7);
        cycle(0, idle, 0, 0, 0, 0, gv, gr);
        chk("full_ready_back", gr, 1);
        repeat (8) cycle(0, idle, 1, 0, 0, 0, gv, gr);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            cycle(1, mk(0, 0, 1, 0, 0), 1, 0, 0, 0, gv, gr);
            chk("wrap_count_le1", bus.count_o <= 1, 1);
            if (i > 0) chk("wrap_issue_each", gv, 1);
        end
        cycle(0, idle, 1, 0, 0, 0, gv, gr);

        // Flush with p9 pending.
        cycle(1, mk(0, 0, 1, 1, 9), 0, 0, 0, 0, gv, gr);
        repeat (4) cycle(1, mk(9, 0, 1, 0, 0), 0, 0, 0, 0, gv, gr);
        cycle(1, mk(0, 0, 1, 0, 0), 1, 0, 0, 1, gv, gr);
        chk("flush_issued_v", gv, 0);
        chk("flush_ready", gr, 0);
        chk("flush_count", bus.count_o, 0);
        cycle(1, mk(9, 9, 0, 0, 0), 0, 0, 0, 0, gv, gr);
        cycle(0, idle, 1, 0, 0, 0, gv, gr);
        chk("flush_p9_ready", gv, 1);

        // Same-register enqueue claim and writeback: the claim wins.
        cycle(1, mk(0, 0, 1, 1, 12), 0, 1, 6'd12, 0, gv, gr);
        cycle(1, mk(12, 0, 1, 0, 0), 1, 0, 0, 0, gv, gr);
        chk("same_first_issues", gv, 1);
        cycle(0, idle, 1, 0, 0, 0, gv, gr);
        chk("same_dep_stall0", gv, 0);
        cycle(0, idle, 1, 0, 0, 0, gv, gr);
        chk("same_dep_stall1", gv, 0);
        cycle(0, idle, 1, 1, 6'd12, 0, gv, gr);
        chk("same_dep_wb", gv, 1);

        // Random traffic, with writebacks biased toward the head's sources.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] wp;
            ins = mk($urandom_range(0, 63), $urandom_range(0, 63), 1'($urandom % 2),
                     1'($urandom % 2), $urandom_range(0, 63));
            wp = 6'($urandom_range(0, 63));
            if (mq.size() != 0 && ($urandom % 2))
                wp = ($urandom % 2) ? mq[0].source_1 : mq[0].source2_imm[5:0];
            cycle(1'($urandom % 4 != 0), ins, 1'($urandom % 4 != 0), 1'($urandom % 2), wp,
                  1'($urandom % 64 == 0), gv, gr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
